// File: rtl/attack_phase_fsm_pkg.sv
// Shared types and helpers for the per-player attack controller.
package attack_phase_fsm_pkg;

  typedef enum logic [2:0] {
    ATK_NONE = 3'd0,
    NEUTRAL  = 3'd1,
    ATK_UP   = 3'd2,
    ATK_DOWN = 3'd3,
    ATK_SIDE = 3'd4
  } attack_state;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } atk_phase_t;

  // Vertical directions beat horizontal ones; no direction gives the neutral move.
  function automatic attack_state decode_dir(input logic up, input logic down,
                                             input logic left, input logic right);
    if (up)                 return ATK_UP;
    else if (down)          return ATK_DOWN;
    else if (left || right) return ATK_SIDE;
    else                    return NEUTRAL;
  endfunction

  // Ambiguous left+right keeps the previous facing.
  function automatic logic next_facing(input logic cur, input logic left, input logic right);
    if (left && !right)      return 1'b1;
    else if (right && !left) return 1'b0;
    else                     return cur;
  endfunction

endpackage

// File: rtl/attack_phase_fsm_phase_timer.sv
// Loadable down-counter that stops at zero; advances only when en is high.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load)              count <= load_val;
      else if (count != '0)  count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/attack_phase_fsm.sv
// Directional attack sequencer: startup/active/recovery phases, late-recovery
// input buffering and hit cancellation, all advancing on frame_tick.
module attack_phase_fsm
  import attack_phase_fsm_pkg::*;
#(
  parameter int STARTUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES   = 4,
  parameter int RECOVERY_FRAMES = 6,
  parameter int BUFFER_FRAMES   = 3,
  parameter int TIMER_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_A,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        interrupt,
  output attack_state atk_state,
  output atk_phase_t  atk_phase,
  output logic        hitbox_active,
  output logic        attack_active,
  output logic        attack_start,
  output logic        facing_left
);

  localparam logic [TIMER_W-1:0] STARTUP_LOAD  = TIMER_W'(STARTUP_FRAMES - 1);
  localparam logic [TIMER_W-1:0] ACTIVE_LOAD   = TIMER_W'(ACTIVE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] RECOVERY_LOAD = TIMER_W'(RECOVERY_FRAMES - 1);
  localparam logic [TIMER_W-1:0] BUF_LIM       = TIMER_W'(BUFFER_FRAMES);

  logic               prev_A;
  logic               buf_valid;
  attack_state        buf_state;
  logic [1:0]         buf_lr;

  logic [TIMER_W-1:0] timer;
  logic               timer_zero;
  logic               load;
  logic [TIMER_W-1:0] load_val;

  logic               press;
  logic               buf_hit;
  attack_state        dir;
  logic               launch;
  attack_state        launch_state;
  logic [1:0]         launch_lr;

  atk_phase_t         phase_n;
  attack_state        state_n;
  logic               facing_n;
  logic               buf_valid_n;
  attack_state        buf_state_n;
  logic [1:0]         buf_lr_n;

  assign press   = btn_A & ~prev_A;
  assign dir     = decode_dir(btn_up, btn_down, btn_left, btn_right);
  // The window is judged on the timer value before this tick, so the exit tick counts too.
  assign buf_hit = press && (timer < BUF_LIM);

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (frame_tick),
    .load     (load),
    .load_val (load_val),
    .count    (timer),
    .zero     (timer_zero)
  );

  always_comb begin
    phase_n      = atk_phase;
    state_n      = atk_state;
    facing_n     = facing_left;
    buf_valid_n  = buf_valid;
    buf_state_n  = buf_state;
    buf_lr_n     = buf_lr;
    load         = 1'b0;
    load_val     = '0;
    launch       = 1'b0;
    launch_state = dir;
    launch_lr    = {btn_left, btn_right};

    if (interrupt) begin
      phase_n     = PH_IDLE;
      state_n     = ATK_NONE;
      buf_valid_n = 1'b0;
      load        = 1'b1;
    end else begin
      case (atk_phase)
        PH_IDLE: begin
          if (press) launch = 1'b1;
        end
        PH_STARTUP: begin
          if (timer_zero) begin
            phase_n  = PH_ACTIVE;
            load     = 1'b1;
            load_val = ACTIVE_LOAD;
          end
        end
        PH_ACTIVE: begin
          if (timer_zero) begin
            phase_n  = PH_RECOVERY;
            load     = 1'b1;
            load_val = RECOVERY_LOAD;
          end
        end
        PH_RECOVERY: begin
          if (timer_zero) begin
            // A press on the exit tick is the latest one, so it overrides the buffer.
            if (buf_hit) begin
              launch = 1'b1;
            end else if (buf_valid) begin
              launch       = 1'b1;
              launch_state = buf_state;
              launch_lr    = buf_lr;
            end else begin
              phase_n = PH_IDLE;
              state_n = ATK_NONE;
            end
            buf_valid_n = 1'b0;
          end else if (buf_hit) begin
            buf_valid_n = 1'b1;
            buf_state_n = dir;
            buf_lr_n    = {btn_left, btn_right};
          end
        end
        default: ;
      endcase

      if (launch) begin
        phase_n  = PH_STARTUP;
        state_n  = launch_state;
        load     = 1'b1;
        load_val = STARTUP_LOAD;
        if (launch_state == ATK_SIDE)
          facing_n = next_facing(facing_left, launch_lr[1], launch_lr[0]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atk_state     <= ATK_NONE;
      atk_phase     <= PH_IDLE;
      hitbox_active <= 1'b0;
      attack_active <= 1'b0;
      attack_start  <= 1'b0;
      facing_left   <= 1'b0;
      prev_A        <= 1'b0;
      buf_valid     <= 1'b0;
      buf_state     <= ATK_NONE;
      buf_lr        <= 2'b00;
    end else begin
      attack_start <= frame_tick & launch;
      if (frame_tick) begin
        atk_state     <= state_n;
        atk_phase     <= phase_n;
        hitbox_active <= (phase_n == PH_ACTIVE);
        attack_active <= (phase_n != PH_IDLE);
        facing_left   <= facing_n;
        prev_A        <= btn_A;
        buf_valid     <= buf_valid_n;
        buf_state     <= buf_state_n;
        buf_lr        <= buf_lr_n;
      end
    end
  end

endmodule

// File: tb/tb_attack_phase_fsm.sv
// Bench for attack_phase_fsm: directed scenarios plus random stimulus against a tick-count model.
module tb_attack_phase_fsm;
  import attack_phase_fsm_pkg::*;

  localparam int S = 3, AF = 4, R = 6, B = 3;
  localparam int TOTAL = S + AF + R;

  logic clk = 1'b0;
  logic reset, frame_tick, btn_A, btn_up, btn_down, btn_left, btn_right, interrupt;
  attack_state atk_state;
  atk_phase_t  atk_phase;
  logic hitbox_active, attack_active, attack_start, facing_left;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  attack_phase_fsm #(.STARTUP_FRAMES(S), .ACTIVE_FRAMES(AF), .RECOVERY_FRAMES(R),
                     .BUFFER_FRAMES(B), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_A(btn_A), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .interrupt(interrupt),
    .atk_state(atk_state), .atk_phase(atk_phase), .hitbox_active(hitbox_active),
    .attack_active(attack_active), .attack_start(attack_start), .facing_left(facing_left)
  );

  // Reference model: an attack is "launched at tick t0"; its phase follows from elapsed ticks.
  int          tick_no = 0;
  logic        m_active, m_start, m_face, m_prevA, m_bvalid;
  int          m_t0;
  attack_state m_move, m_bmove;
  logic [1:0]  m_blr;

  task automatic model_reset();
    m_active = 0; m_start = 0; m_face = 0; m_prevA = 0; m_bvalid = 0;
    m_t0 = 0; m_move = ATK_NONE; m_bmove = ATK_NONE; m_blr = 2'b00;
  endtask

  function automatic attack_state ref_dir(input logic u, d, l, r);
    if (u) return ATK_UP;
    if (d) return ATK_DOWN;
    if (l | r) return ATK_SIDE;
    return NEUTRAL;
  endfunction

  task automatic ref_launch(input attack_state mv, input logic [1:0] lr);
    m_active = 1; m_t0 = tick_no; m_move = mv; m_start = 1;
    if (mv == ATK_SIDE) begin
      if (lr == 2'b10) m_face = 1;
      else if (lr == 2'b01) m_face = 0;
    end
  endtask

  task automatic model_tick(input logic a, u, d, l, r, irq);
    logic press;
    int e;
    press = a & ~m_prevA;
    m_prevA = a;
    m_start = 0;
    if (irq) begin
      m_active = 0; m_bvalid = 0;
    end else if (!m_active) begin
      if (press) ref_launch(ref_dir(u, d, l, r), {l, r});
    end else begin
      e = tick_no - m_t0;
      if (press && B > 0 && e >= TOTAL - B + 1) begin
        m_bvalid = 1; m_bmove = ref_dir(u, d, l, r); m_blr = {l, r};
      end
      if (e == TOTAL) begin
        if (m_bvalid) begin
          m_bvalid = 0;
          ref_launch(m_bmove, m_blr);
        end else m_active = 0;
      end
    end
  endtask

  function automatic atk_phase_t exp_phase();
    int e;
    if (!m_active) return PH_IDLE;
    e = tick_no - m_t0;
    if (e < S) return PH_STARTUP;
    if (e < S + AF) return PH_ACTIVE;
    return PH_RECOVERY;
  endfunction

  function automatic logic [8:0] exp_vec();
    atk_phase_t p;
    p = exp_phase();
    return {p, (m_active ? m_move : ATK_NONE), p == PH_ACTIVE, p != PH_IDLE, m_start, m_face};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {atk_phase, atk_state, hitbox_active, attack_active, attack_start, facing_left};
  endfunction

  task automatic step(input logic a, u, d, l, r, irq);
    @(negedge clk);
    btn_A = a; btn_up = u; btn_down = d; btn_left = l; btn_right = r; interrupt = irq;
    frame_tick = 1;
    @(posedge clk);
    tick_no++;
    model_tick(a, u, d, l, r, irq);
    #1 frame_tick = 0;
  endtask

  task automatic gap();
    @(negedge clk);
    frame_tick = 0;
    @(posedge clk);
    m_start = 0;
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < TOTAL + 2; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== {PH_IDLE, ATK_NONE, 4'b0000}) begin
      errors++; $display("FAIL reset_values got=%b want=%b", obs_vec(), {PH_IDLE, ATK_NONE, 4'b0000});
    end
  endtask

  task automatic test_neutral_timeline();
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (atk_phase !== PH_STARTUP || atk_state !== NEUTRAL || attack_start !== 1'b1) begin
      errors++; $display("FAIL neutral_launch got=%b want phase=STARTUP state=NEUTRAL start=1", obs_vec());
    end
    gap();
    checks++;
    if (attack_start !== 1'b0 || atk_phase !== PH_STARTUP) begin
      errors++; $display("FAIL start_pulse_width got start=%b phase=%0d want 0/STARTUP", attack_start, atk_phase);
    end
    for (int i = 1; i <= TOTAL; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL neutral_tl k+%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
      if (i == S) begin
        checks++;
        if (atk_phase !== PH_ACTIVE || hitbox_active !== 1'b1) begin
          errors++; $display("FAIL neutral_active_entry got phase=%0d hb=%b want ACTIVE/1", atk_phase, hitbox_active);
        end
      end
    end
    checks++;
    if (atk_phase !== PH_IDLE || attack_active !== 1'b0 || atk_state !== ATK_NONE) begin
      errors++; $display("FAIL neutral_idle_end got=%b want IDLE/NONE", obs_vec());
    end
  endtask

  task automatic test_direction();
    logic [3:0]  dirs [6] = '{4'b1110, 4'b0101, 4'b0010, 4'b0011, 4'b0001, 4'b0000};
    attack_state wst  [6] = '{ATK_UP, ATK_DOWN, ATK_SIDE, ATK_SIDE, ATK_SIDE, NEUTRAL};
    logic        wface[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1, dirs[i][3], dirs[i][2], dirs[i][1], dirs[i][0], 0);
      checks++;
      if (atk_state !== wst[i] || facing_left !== wface[i] || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL direction_%0d got state=%0d face=%b vec=%b want state=%0d face=%b vec=%b",
                 i, atk_state, facing_left, obs_vec(), wst[i], wface[i], exp_vec());
      end
      settle();
    end
  endtask

  task automatic test_hold();
    int starts = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0, 0, 0);
      starts += int'(attack_start);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_tick_%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (starts != 1) begin
      errors++; $display("FAIL hold_single_attack got starts=%0d want 1", starts);
    end
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (attack_start !== 1'b1 || atk_phase !== PH_STARTUP) begin
      errors++; $display("FAIL hold_repress got start=%b phase=%0d want 1/STARTUP", attack_start, atk_phase);
    end
    settle();
  endtask

  task automatic test_buffer();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (atk_phase !== PH_RECOVERY) begin
      errors++; $display("FAIL buffer_k12 got phase=%0d want RECOVERY", atk_phase);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (atk_phase !== PH_STARTUP || atk_state !== ATK_UP || attack_start !== 1'b1) begin
      errors++; $display("FAIL buffer_relaunch got=%b want STARTUP/ATK_UP/start=1", obs_vec());
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL buffer_model got=%b want=%b", obs_vec(), exp_vec());
    end
    settle();
  endtask

  task automatic test_drop();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 9; i <= 13; i++) step(0, 0, 0, 0, 0, 0);
    checks++;
    if (atk_phase !== PH_IDLE || atk_state !== ATK_NONE || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL drop_early_press got=%b want IDLE/NONE", obs_vec());
    end
    settle();
  endtask

  task automatic test_interrupt();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1);
    checks++;
    if (atk_phase !== PH_IDLE || atk_state !== ATK_NONE || hitbox_active !== 1'b0 || attack_start !== 1'b0) begin
      errors++; $display("FAIL interrupt_cancel got=%b want IDLE/NONE/hb=0/start=0", obs_vec());
    end
    for (int i = 0; i < TOTAL + 2; i++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (attack_active !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL interrupt_quiet_%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
    settle();
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if (obs_vec() !== {PH_IDLE, ATK_NONE, 4'b0000}) begin
      errors++; $display("FAIL async_reset got=%b want=%b", obs_vec(), {PH_IDLE, ATK_NONE, 4'b0000});
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (atk_phase !== PH_STARTUP || atk_state !== ATK_DOWN || attack_start !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL post_reset_launch got=%b want=%b", obs_vec(), exp_vec());
    end
    settle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        gap();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_gap_%0d got=%b want=%b", i, obs_vec(), exp_vec());
        end
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d got=%b want=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1; frame_tick = 0; interrupt = 0;
    btn_A = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 0;
    test_neutral_timeline();
    test_direction();
    test_hold();
    test_buffer();
    test_drop();
    test_interrupt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
